// File: rtl/encode_instn.sv
// RV32I instruction encoder: packs decoded field bundles into 32-bit words
// behind a one-entry output register, tagging each word with a running address.
module encode_instn #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic [2:0]  out_format,
  output logic        err_undef,
  output logic        err_align,
  input  logic        clr_err
);

  localparam logic [2:0] UNDEF_TYPE = 3'd0;
  localparam logic [2:0] R_TYPE     = 3'd1;
  localparam logic [2:0] I_TYPE     = 3'd2;
  localparam logic [2:0] S_TYPE     = 3'd3;
  localparam logic [2:0] B_TYPE     = 3'd4;
  localparam logic [2:0] U_TYPE     = 3'd5;
  localparam logic [2:0] J_TYPE     = 3'd6;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic [31:0] addr_cnt;
  logic [2:0]  fmt;
  logic [31:0] word;
  logic        accept;
  logic        new_undef;
  logic        new_align;

  always_comb begin
    fmt = UNDEF_TYPE;
    case (opcode)
      7'd3, 7'd19, 7'd103: fmt = I_TYPE;
      7'd23, 7'd55:        fmt = U_TYPE;
      7'd35:               fmt = S_TYPE;
      7'd51:               fmt = R_TYPE;
      7'd99:               fmt = B_TYPE;
      7'd111:              fmt = J_TYPE;
      default:             fmt = UNDEF_TYPE;
    endcase
  end

  always_comb begin
    word = 32'd0;
    case (fmt)
      R_TYPE:  word = {func7, rs2, rs1, func3, rd, opcode};
      I_TYPE:  word = {imm[11:0], rs1, func3, rd, opcode};
      S_TYPE:  word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      B_TYPE:  word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      U_TYPE:  word = {imm[31:12], rd, opcode};
      J_TYPE:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = 32'd0;
    endcase
  end

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign in_ready  = ~rst & ((state == EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == FULL);
  assign new_undef = accept & (fmt == UNDEF_TYPE);
  assign new_align = accept & ((fmt == B_TYPE) | (fmt == J_TYPE)) & imm[0];

  // Undefined bundles are consumed but never loaded, so the address counter only
  // moves when a word actually lands in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_inst   <= 32'd0;
      out_addr   <= 32'd0;
      out_format <= UNDEF_TYPE;
      addr_cnt   <= BASE_ADDR;
      err_undef  <= 1'b0;
      err_align  <= 1'b0;
    end else begin
      if (accept && fmt != UNDEF_TYPE) begin
        state      <= FULL;
        out_inst   <= word;
        out_addr   <= addr_cnt;
        out_format <= fmt;
        addr_cnt   <= addr_cnt + 32'd4;
      end else if (state == FULL && out_ready) begin
        state <= EMPTY;
      end

      if (new_undef)    err_undef <= 1'b1;
      else if (clr_err) err_undef <= 1'b0;

      if (new_align)    err_align <= 1'b1;
      else if (clr_err) err_align <= 1'b0;
    end
  end

endmodule
